mult_share_arbiter: RTL and testbench



---
 rtl/mult_arb_pkg.sv | 15 +
 rtl/mult_arb_rr_arbiter.sv | 35 +++
 rtl/multi_16bit.sv | 21 ++
 rtl/mult_share_arbiter.sv | 146 ++++++++++++++
 tb/tb_mult_share_arbiter.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
// Optional stats build: define MULT_ARB_STATS_EN.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    RESP
  } state_t;

  localparam int OPW         = 16;
  localparam int PW          = 32;
  localparam int NUM_REQ_DEF = 4;

endpackage

// File: rtl/mult_arb_rr_arbiter.sv
// Combinational round-robin arbiter: first set request
// at or above ptr_i, wrapping around.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  logic          found;
  logic [IW-1:0] k;
  int            j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    k     = '0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr_i) + i) % N;
      k = IW'(j);
      if (en_i && !found && req_i[k]) begin
        found    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/multi_16bit.sv
// Unsigned 16x16 combinational array multiplier.
// Shared datapath; rows accumulate shifted partial products.
module multi_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  logic [31:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < 16; i++) begin
      if (b[i]) begin
        acc = acc + ({16'b0, a} << i);
      end
    end
    p = acc;
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Time-shares one multi_16bit among NUM_REQ requesters.
// Optional per-requester grant counters: MULT_ARB_STATS_EN.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [OPW*NUM_REQ-1:0] req_a,
  input  logic [OPW*NUM_REQ-1:0] req_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [PW-1:0]          rsp_p,
`ifdef MULT_ARB_STATS_EN
  input  logic                   stats_clr,
  output logic [16*NUM_REQ-1:0]  grant_cnt,
`endif
  output logic                   busy
);

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic [OPW-1:0] op_a_q, op_a_d;
  logic [OPW-1:0] op_b_q, op_b_d;
  logic [PW-1:0]  rsp_p_q, rsp_p_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic           rsp_valid_q, rsp_valid_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     gnt_idx;
  logic [PW-1:0]      prod;
  logic               arb_en;

  // Gated by rst_n so no grant is offered while held in reset.
  assign arb_en = (state_q == IDLE) && rst_n;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .req_i(req_valid),
    .ptr_i(rr_ptr_q),
    .en_i (arb_en),
    .gnt_o(gnt),
    .idx_o(gnt_idx)
  );

  multi_16bit u_mul (
    .a(op_a_q),
    .b(op_b_q),
    .p(prod)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_id_d    = gnt_id_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    rsp_p_d     = rsp_p_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          op_a_d   = req_a[OPW*gnt_idx +: OPW];
          op_b_d   = req_b[OPW*gnt_idx +: OPW];
          gnt_id_d = gnt_idx;
          state_d  = MUL;
        end
      end
      MUL: begin
        rsp_p_d     = prod;
        rsp_id_d    = gnt_id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
          if (gnt_id_q == IDW'(NUM_REQ - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = gnt_id_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_id_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_p_q     <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_id_q    <= gnt_id_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      rsp_p_q     <= rsp_p_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready = gnt;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;
  assign busy      = (state_q != IDLE);

`ifdef MULT_ARB_STATS_EN
  logic [15:0] cnt_q [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q[g] <= '0;
      end else if (stats_clr) begin
        cnt_q[g] <= '0;
      end else if (req_ready[g] && req_valid[g]
                   && cnt_q[g] != 16'hFFFF) begin
        cnt_q[g] <= cnt_q[g] + 16'd1;
      end
    end
    assign grant_cnt[16*g +: 16] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter.
// Stats tests are built only with MULT_ARB_STATS_EN.
module tb_mult_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_p;
  logic        busy;
`ifdef MULT_ARB_STATS_EN
  logic        stats_clr;
  logic [63:0] grant_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_share_arbiter #(
    .NUM_REQ(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_p    (rsp_p),
`ifdef MULT_ARB_STATS_EN
    .stats_clr(stats_clr),
    .grant_cnt(grant_cnt),
`endif
    .busy     (busy)
  );

  task automatic do_reset;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
`ifdef MULT_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    req_a     = '0;
    req_b     = '0;
`ifdef MULT_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_id, busy} !== 8'h00
        || rsp_p !== 32'h0) begin
      errors++;
      $display("FAIL reset_outs: ready=%b v=%b id=%0d p=%h busy=%b want 0",
               req_ready, rsp_valid, rsp_id, rsp_p, busy);
    end
    do_reset();
  endtask

  task automatic test_single;
    do_reset();
    req_valid  = 4'b0001;
    req_a[15:0] = 16'd2;
    req_b[15:0] = 16'd3;
    #1;
    checks++;
    if (req_ready !== 4'b0001 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_grant: ready=%b busy=%b want 0001 0",
               req_ready, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 4'b0) begin
      errors++;
      $display("FAIL single_mul: busy=%b v=%b ready=%b want 1 0 0000",
               busy, rsp_valid, req_ready);
    end
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_p !== 32'd6
        || rsp_id !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_rsp: v=%b p=%0d id=%0d busy=%b want 1 6 0 1",
               rsp_valid, rsp_p, rsp_id, busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%b v=%b want 0 0", busy, rsp_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] exp_gnt;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req_a[16*i +: 16] = 16'(i + 1);
      req_b[16*i +: 16] = 16'h0010;
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_gnt = 4'(1 << (k % 4));
      #1;
      checks++;
      if (req_ready !== exp_gnt) begin
        errors++;
        $display("FAIL b2b_grant%0d: ready=%b want %b",
                 k, req_ready, exp_gnt);
      end
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4)
          || rsp_p !== 32'(16 * (k % 4 + 1))) begin
        errors++;
        $display("FAIL b2b_rsp%0d: v=%b id=%0d p=%0d want 1 %0d %0d",
                 k, rsp_valid, rsp_id, rsp_p, k % 4, 16 * (k % 4 + 1));
      end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_arith;
    logic [1:0]  vi [2];
    logic [15:0] va [2];
    logic [15:0] vb [2];
    logic [31:0] vp [2];
    vi[0] = 2'd0; va[0] = 16'hFFFF; vb[0] = 16'hFFFF;
    vp[0] = 32'hFFFE0001;
    vi[1] = 2'd1; va[1] = 16'd756; vb[1] = 16'd139;
    vp[1] = 32'd105084;
    do_reset();
    for (int v = 0; v < 2; v++) begin
      req_valid = 4'(1 << vi[v]);
      req_a[16*vi[v] +: 16] = va[v];
      req_b[16*vi[v] +: 16] = vb[v];
      #1;
      checks++;
      if (req_ready !== 4'(1 << vi[v])) begin
        errors++;
        $display("FAIL arith_grant%0d: ready=%b", v, req_ready);
      end
      @(negedge clk);
      req_valid = '0;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_p !== vp[v] || rsp_id !== vi[v]) begin
        errors++;
        $display("FAIL arith_rsp%0d: v=%b p=%h id=%0d want 1 %h %0d",
                 v, rsp_valid, rsp_p, rsp_id, vp[v], vi[v]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    req_a[47:32] = 16'd5;
    req_b[47:32] = 16'd7;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_grant: ready=%b want 0100", req_ready);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_p !== 32'd35 || rsp_id !== 2'd2) begin
      errors++;
      $display("FAIL bp_rsp: v=%b p=%0d id=%0d want 1 35 2",
               rsp_valid, rsp_p, rsp_id);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_p !== 32'd35
          || rsp_id !== 2'd2 || req_ready !== 4'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: v=%b p=%0d id=%0d ready=%b",
                 c, rsp_valid, rsp_p, rsp_id, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_regrant: ready=%b v=%b want 0100 0",
               req_ready, rsp_valid);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_rr_pointer;
    do_reset();
    req_valid = 4'b0010;
    req_a[31:16] = 16'd1;
    req_b[31:16] = 16'd1;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    req_valid = 4'b0101;
    req_a[15:0]  = 16'd3;
    req_b[15:0]  = 16'd3;
    req_a[47:32] = 16'd4;
    req_b[47:32] = 16'd4;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL rr_first: ready=%b want 0100", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0001;
    @(negedge clk);
    checks++;
    if (rsp_id !== 2'd2 || rsp_p !== 32'd16) begin
      errors++;
      $display("FAIL rr_rsp2: id=%0d p=%0d want 2 16", rsp_id, rsp_p);
    end
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rr_second: ready=%b want 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_id !== 2'd0 || rsp_p !== 32'd9) begin
      errors++;
      $display("FAIL rr_rsp0: id=%0d p=%0d want 0 9", rsp_id, rsp_p);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    logic seen;
    do_reset();
    req_valid = 4'b0010;
    req_a[31:16] = 16'd2;
    req_b[31:16] = 16'd2;
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    req_valid = 4'b1000;
    req_a[63:48] = 16'd342;
    req_b[63:48] = 16'd939;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_mul: busy=%b want 1", busy);
    end
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_id, busy} !== 8'h00
        || rsp_p !== 32'h0) begin
      errors++;
      $display("FAIL midrst_outs: ready=%b v=%b id=%0d p=%h busy=%b",
               req_ready, rsp_valid, rsp_id, rsp_p, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL midrst_norsp: activity=%b want 0", seen);
    end
    req_valid = 4'b0101;
    req_a[15:0]  = 16'd9;
    req_b[15:0]  = 16'd2;
    req_a[47:32] = 16'd1;
    req_b[47:32] = 16'd1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_ptr: ready=%b want 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_id !== 2'd0 || rsp_p !== 32'd18) begin
      errors++;
      $display("FAIL midrst_rsp: id=%0d p=%0d want 0 18", rsp_id, rsp_p);
    end
    @(negedge clk);
  endtask

`ifdef MULT_ARB_STATS_EN
  task automatic test_stats;
    do_reset();
    checks++;
    if (grant_cnt !== 64'h0) begin
      errors++;
      $display("FAIL stats_rst: cnt=%h want 0", grant_cnt);
    end
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    checks++;
    if (grant_cnt !== 64'h1) begin
      errors++;
      $display("FAIL stats_inc: cnt=%h want 1", grant_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    req_valid = 4'b0010;
    stats_clr = 1'b1;
    @(negedge clk);
    req_valid = '0;
    stats_clr = 1'b0;
    checks++;
    if (grant_cnt !== 64'h0) begin
      errors++;
      $display("FAIL stats_clr: cnt=%h want 0", grant_cnt);
    end
    @(negedge clk);
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_arith();
    test_backpressure();
    test_rr_pointer();
    test_reset_mid_op();
`ifdef MULT_ARB_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
